// File: rtl/qmem_pkg.sv
// Shared QMEM definitions: bus width defaults and the
// SRAM controller state encoding.
package qmem_pkg;

   localparam int QMEM_AW = 22;
   localparam int QMEM_DW = 16;
   localparam int QMEM_SW = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_WR      = 3'd2,
      ST_WR_HOLD = 3'd3,
      ST_DONE    = 3'd4
   } sram_state_t;

endpackage

// File: rtl/qmem_sram.sv
// QMEM slave to asynchronous 16-bit SRAM controller.
// Every pad control is a flop decoded from the next state.
module qmem_sram
   import qmem_pkg::*;
#(
   parameter int QAW   = QMEM_AW,
   parameter int QDW   = QMEM_DW,
   parameter int QSW   = QMEM_SW,
   parameter int RD_WS = 2,
   parameter int WR_WS = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [QAW-1:0] adr,
   input  logic           cs,
   input  logic           we,
   input  logic [QSW-1:0] sel,
   input  logic [QDW-1:0] dat_w,
   output logic [QDW-1:0] dat_r,
   output logic           ack,
   output logic           err,
   output logic [QAW-2:0] sram_adr,
   output logic [15:0]    sram_dat_w,
   input  logic [15:0]    sram_dat_r,
   output logic           sram_dat_oe,
   output logic           sram_ce_n,
   output logic           sram_oe_n,
   output logic           sram_we_n,
   output logic           sram_ub_n,
   output logic           sram_lb_n
);

   sram_state_t state;
   sram_state_t state_nxt;
   logic [3:0]  cnt;
   logic        start;
   logic        cnt_zero;
   logic        unused_adr0;

   assign unused_adr0 = adr[0];
   assign err         = 1'b0;
   assign start       = (state == ST_IDLE) && cs;
   assign cnt_zero    = (cnt == 4'd0);

   // State register; reset wins over any request.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (cs) state_nxt = we ? ST_WR : ST_RD;
         ST_RD:      if (cnt_zero) state_nxt = ST_DONE;
         ST_WR:      if (cnt_zero) state_nxt = ST_WR_HOLD;
         ST_WR_HOLD: state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Wait-state counter: loaded on accept, counts down in RD/WR.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 4'd0;
      end else if (start) begin
         cnt <= we ? 4'(WR_WS) : 4'(RD_WS);
      end else if ((state == ST_RD || state == ST_WR) && !cnt_zero) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Address/data capture on accept; read data on last RD cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_adr   <= '0;
         sram_dat_w <= '0;
         dat_r      <= '0;
      end else begin
         if (start) begin
            sram_adr   <= adr[QAW-1:1];
            sram_dat_w <= 16'(dat_w);
         end
         if (state == ST_RD && cnt_zero) dat_r <= QDW'(sram_dat_r);
      end
   end

   // Registered pad controls, decoded from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack         <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
         sram_dat_oe <= 1'b0;
      end else begin
         ack         <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
         sram_dat_oe <= 1'b0;
         unique case (state_nxt)
            ST_RD, ST_WR, ST_WR_HOLD: begin
               sram_ce_n <= 1'b0;
               sram_ub_n <= start ? ~sel[1] : sram_ub_n;
               sram_lb_n <= start ? ~sel[0] : sram_lb_n;
               sram_oe_n <= (state_nxt != ST_RD);
               sram_we_n <= (state_nxt != ST_WR);
               sram_dat_oe <= (state_nxt != ST_RD);
            end
            ST_DONE: ack <= 1'b1;
            default: ack <= 1'b0;
         endcase
      end
   end

endmodule
